// File: rtl/aib_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | aib_pkg : shared state encoding and default timing for the AIB sequencer
// | Rev 1.0
// +---------------------------------------------------------------------------
package aib_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    HOLD = 3'd2,
    WAIT = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } aib_seq_state_e;

  localparam int RST_HOLD_CYC_DEF = 16;
  localparam int LOCK_EDGES_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF  = 256;

endpackage
`default_nettype wire

// File: rtl/aib_edge_sync.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | aib_edge_sync : 2-FF synchronizer with a one-cycle rising-edge pulse
// | Rev 1.0
// +---------------------------------------------------------------------------
module aib_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign rise = sync & ~dly;

endmodule
`default_nettype wire

// File: rtl/aib_ch_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | aib_ch_seq : bring-up sequencer owning reset/bypass of the AIB channels
// | Rev 1.0
// +---------------------------------------------------------------------------
module aib_ch_seq
  import aib_pkg::*;
#(
  parameter int ChCnt      = 4,
  parameter int RstHoldCyc = RST_HOLD_CYC_DEF,
  parameter int LockEdges  = LOCK_EDGES_DEF,
  parameter int TimeoutCyc = TIMEOUT_CYC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [ChCnt-1:0] i_ch_en,
  input  logic [ChCnt-1:0] i_ch_bypass,
  input  logic [ChCnt-1:0] i_aib_slow_clk,
  output logic [ChCnt-1:0] o_ch_rst_n,
  output logic [ChCnt-1:0] o_ch_bypass,
  output logic             o_busy,
  output logic             o_done,
  output logic [ChCnt-1:0] o_ch_ok,
  output logic [ChCnt-1:0] o_ch_fail
);

  localparam int IdxW  = (ChCnt > 1) ? $clog2(ChCnt) : 1;
  localparam int HoldW = $clog2(RstHoldCyc + 1);
  localparam int CycW  = $clog2(TimeoutCyc + 1);
  localparam int CntW  = (HoldW > CycW) ? HoldW : CycW;
  localparam int EdgeW = $clog2(LockEdges + 1);

  localparam logic [CntW-1:0]  HOLD_LAST = CntW'(RstHoldCyc - 1);
  localparam logic [CntW-1:0]  WAIT_LAST = CntW'(TimeoutCyc - 1);
  localparam logic [EdgeW-1:0] EDGE_LAST = EdgeW'(LockEdges - 1);
  localparam logic [IdxW-1:0]  IDX_LAST  = IdxW'(ChCnt - 1);

  aib_seq_state_e   state, state_d;
  logic [IdxW-1:0]  idx, idx_d;
  logic [CntW-1:0]  cyc_cnt, cyc_d;
  logic [EdgeW-1:0] edge_cnt, edge_d;
  logic [ChCnt-1:0] en_q, en_d;
  logic [ChCnt-1:0] rst_q, rst_d;
  logic [ChCnt-1:0] byp_q, byp_d;
  logic [ChCnt-1:0] ok_q, ok_d;
  logic [ChCnt-1:0] fail_q, fail_d;
  logic [ChCnt-1:0] slow_rise;

  logic cur_rise;
  logic cur_en;
  logic last_idx;
  logic lock;
  logic timeout;

  for (genvar g = 0; g < ChCnt; g++) begin : g_sync
    aib_edge_sync u_sync (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .async_in (i_aib_slow_clk[g]),
      .rise     (slow_rise[g])
    );
  end

  assign cur_rise = slow_rise[idx];
  assign cur_en   = en_q[idx];
  assign last_idx = (idx == IDX_LAST);
  // A lock on the final WAIT cycle takes priority over the timeout.
  assign lock     = cur_rise && (edge_cnt == EDGE_LAST);
  assign timeout  = (cyc_cnt == WAIT_LAST);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cyc_d   = cyc_cnt;
    edge_d  = edge_cnt;
    en_d    = en_q;
    rst_d   = rst_q;
    byp_d   = byp_q;
    ok_d    = ok_q;
    fail_d  = fail_q;

    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          en_d    = i_ch_en;
          byp_d   = i_ch_bypass;
          rst_d   = '0;
          ok_d    = '0;
          fail_d  = '0;
          idx_d   = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        if (cur_en) begin
          cyc_d   = '0;
          edge_d  = '0;
          state_d = HOLD;
        end else if (last_idx) begin
          state_d = DONE;
        end else begin
          idx_d = idx + IdxW'(1);
        end
      end
      HOLD: begin
        if (cyc_cnt == HOLD_LAST) begin
          rst_d[idx] = 1'b1;
          cyc_d      = '0;
          edge_d     = '0;
          state_d    = WAIT;
        end else begin
          cyc_d = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CntW'(1);
        end
      end
      WAIT: begin
        if (lock) begin
          ok_d[idx] = 1'b1;
          state_d   = NEXT;
        end else if (timeout) begin
          fail_d[idx] = 1'b1;
          rst_d[idx]  = 1'b0;
          state_d     = NEXT;
        end else begin
          cyc_d = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CntW'(1);
          if (cur_rise) begin
            edge_d = (&edge_cnt) ? edge_cnt : edge_cnt + EdgeW'(1);
          end
        end
      end
      NEXT: begin
        if (last_idx) begin
          state_d = DONE;
        end else begin
          idx_d   = idx + IdxW'(1);
          state_d = SEL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cyc_cnt  <= '0;
      edge_cnt <= '0;
      en_q     <= '0;
      rst_q    <= '0;
      byp_q    <= '0;
      ok_q     <= '0;
      fail_q   <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      cyc_cnt  <= cyc_d;
      edge_cnt <= edge_d;
      en_q     <= en_d;
      rst_q    <= rst_d;
      byp_q    <= byp_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
    end
  end

  assign o_ch_rst_n  = rst_q;
  assign o_ch_bypass = byp_q;
  assign o_ch_ok     = ok_q;
  assign o_ch_fail   = fail_q;
  assign o_busy      = (state == SEL) || (state == HOLD) || (state == WAIT) || (state == NEXT);
  assign o_done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_aib_ch_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | tb_aib_ch_seq : directed self-checking bench for aib_ch_seq
// | Rev 1.0
// +---------------------------------------------------------------------------
module tb_aib_ch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ch_en = '0;
  logic [3:0] ch_byp = '0;
  logic [3:0] slow = '0;
  logic [3:0] run = '0;
  logic [3:0] man = '0;
  logic [2:0] ph = '0;

  logic [3:0] ch_rst_n;
  logic [3:0] ch_bypass;
  logic [3:0] ch_ok;
  logic [3:0] ch_fail;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Free-running slow clocks of period 8 clk cycles, or manual/stuck levels.
  always @(negedge clk) begin
    ph = ph + 3'd1;
    for (int i = 0; i < 4; i++) slow[i] = run[i] ? ph[2] : man[i];
  end

  aib_ch_seq dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_ch_en        (ch_en),
    .i_ch_bypass    (ch_byp),
    .i_aib_slow_clk (slow),
    .o_ch_rst_n     (ch_rst_n),
    .o_ch_bypass    (ch_bypass),
    .o_busy         (busy),
    .o_done         (done),
    .o_ch_ok        (ch_ok),
    .o_ch_fail      (ch_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] en, input logic [3:0] byp);
    ch_en  = en;
    ch_byp = byp;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (!done && k < limit) begin
      tick();
      k++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k;
    int cnt;
    int dec;
    logic leak;

    repeat (3) tick();
    check("rst_ch_rst_n", ch_rst_n, 4'h0);
    check("rst_bypass", ch_bypass, 4'h0);
    check("rst_flags", {busy, done, ch_ok, ch_fail}, 10'h0);
    rst_n = 1'b1;
    tick();

    // All channels healthy
    run = 4'hF;
    do_start(4'hF, 4'h0);
    check("t1_busy", busy, 1);
    check("t1_rst_lo", ch_rst_n, 4'h0);
    k = 1;
    while (!ch_rst_n[0] && k < 100) begin
      tick();
      k++;
    end
    check("t1_rel_cyc", k, 18);
    wait_done(2000);
    check("t1_ok", ch_ok, 4'hF);
    check("t1_fail", ch_fail, 4'h0);
    check("t1_rst_n", ch_rst_n, 4'hF);
    check("t1_busy_lo", busy, 0);

    // Channel 2 slow clock stuck low
    run = 4'b1011;
    do_start(4'hF, 4'h0);
    k = 0;
    cnt = 0;
    while (!ch_fail[2] && !done && k < 3000) begin
      tick();
      k++;
      if (ch_rst_n[2]) cnt++;
    end
    check("t2_wait_cyc", cnt, 256);
    wait_done(2000);
    check("t2_fail", ch_fail, 4'b0100);
    check("t2_ok", ch_ok, 4'b1011);
    check("t2_rst_n", ch_rst_n, 4'b1011);

    // Partial enable with bypass
    run = 4'hF;
    do_start(4'b1010, 4'b0011);
    check("t3_bypass_n1", ch_bypass, 4'b0011);
    leak = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      tick();
      k++;
      if (ch_rst_n[0] | ch_rst_n[2]) leak = 1'b1;
    end
    check("t3_done", done, 1);
    check("t3_leak", leak, 0);
    check("t3_ok", ch_ok, 4'b1010);
    check("t3_fail", ch_fail, 4'h0);
    check("t3_rst_n", ch_rst_n, 4'b1010);
    check("t3_bypass", ch_bypass, 4'b0011);

    // Start while busy is ignored; restart after done
    do_start(4'hF, 4'h0);
    k = 0;
    while (!ch_rst_n[1] && k < 500) begin
      tick();
      k++;
    end
    check("t4_ch1_wait", ch_rst_n[1], 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy", busy, 1);
    check("t4_ch0_kept", ch_rst_n[0], 1);
    check("t4_ok0_kept", ch_ok[0], 1);
    wait_done(2000);
    check("t4_ok", ch_ok, 4'hF);
    do_start(4'hF, 4'hF);
    check("t4_re_rst", ch_rst_n, 4'h0);
    check("t4_re_okfail", {ch_ok, ch_fail}, 8'h0);
    check("t4_re_flags", {busy, done}, 2'b10);
    check("t4_re_bypass", ch_bypass, 4'hF);

    // Asynchronous reset during HOLD of channel 1
    k = 0;
    while (!ch_ok[0] && k < 500) begin
      tick();
      k++;
    end
    check("t5_ok0", ch_ok[0], 1);
    repeat (3) tick();
    check("t5_in_hold", {busy, ch_rst_n[1]}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", ch_rst_n, 4'h0);
    check("t5_async_byp", ch_bypass, 4'h0);
    check("t5_async_flags", {busy, done, ch_ok, ch_fail}, 10'h0);
    #2;
    rst_n = 1'b1;
    repeat (20) tick();
    check("t5_idle", {busy, done, ch_rst_n}, 6'h0);

    // Fourth edge lands on the timeout cycle: lock wins
    run = 4'h0;
    man = 4'h0;
    do_start(4'b0001, 4'h0);
    k = 1;
    dec = 0;
    while (k < 320 && dec == 0) begin
      man[0] = ((k >= 30 && k < 34) || (k >= 40 && k < 44) ||
                (k >= 50 && k < 54) || (k >= 271 && k < 281)) ? 1'b1 : 1'b0;
      tick();
      k++;
      if (ch_ok[0] | ch_fail[0]) dec = k;
    end
    man = 4'h0;
    check("t6_dec_cyc", dec, 274);
    check("t6_ok0", ch_ok[0], 1);
    check("t6_fail0", ch_fail[0], 0);
    wait_done(100);
    check("t6_rst_n", ch_rst_n, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
